train_state: RTL and testbench



---
 rtl/train_state_pkg.sv | 9 +
 rtl/train_state_sensor_sync.sv | 18 +
 rtl/train_state.sv | 41 ++++
 tb/tb_train_state.sv | 112 +++++++++++
 4 files changed

// File: rtl/train_state_pkg.sv
// train_state_pkg: FSM states plus direction and switch encodings for the two-train loop controller.
package train_state_pkg;
  typedef enum logic [2:0] {ABOUT, AIN, BIN, ASTOP, BSTOP} state_e;
  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_FWD = 2'b01;
  localparam logic [1:0] DIR_REV = 2'b10;
  localparam logic SW_STRAIGHT = 1'b0;
  localparam logic SW_DIVERT = 1'b1;
endpackage

// File: rtl/train_state_sensor_sync.sv
// sensor_sync: two-stage synchronizer for the four track sensors, cleared to zero on reset.
module sensor_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:1] d,
  output logic [4:1] q
);
  logic [4:1] stage1_d, stage1_q, stage2_d, stage2_q;
  always_comb begin
    stage1_d = rst ? 4'b0000 : d;
    stage2_d = rst ? 4'b0000 : stage1_q;
  end
  always_ff @(posedge clk) begin
    stage1_q <= stage1_d;
    stage2_q <= stage2_d;
  end
  assign q = stage2_q;
endmodule

// File: rtl/train_state.sv
// train_state: Moore FSM granting the shared section to one train at a time; TRAIN_STATE_SENSOR_SYNC_EN adds a 2-flop sensor synchronizer.
module train_state
  import train_state_pkg::*;
(
  input  logic       Clock,
  input  logic       RESET,
  input  logic [4:1] SR,
  output logic [3:1] SW,
  output logic [1:0] DA,
  output logic [1:0] DB
);
  logic [4:1] sr;
  state_e state_d, state_q;
  logic divert;
`ifdef TRAIN_STATE_SENSOR_SYNC_EN
  sensor_sync u_sync (.clk(Clock), .rst(RESET), .d(SR), .q(sr));
`else
  assign sr = SR;
`endif
  always_comb begin
    state_d = ABOUT;
    case (state_q)
      ABOUT:   state_d = sr[1] ? AIN : sr[2] ? BIN : ABOUT;
      AIN:     state_d = sr[2] ? BSTOP : sr[4] ? ABOUT : AIN;
      BIN:     state_d = sr[1] ? ASTOP : sr[3] ? ABOUT : BIN;
      ASTOP:   state_d = sr[3] ? BIN : ASTOP;
      BSTOP:   state_d = sr[4] ? AIN : BSTOP;
      default: state_d = ABOUT;
    endcase
    if (RESET) state_d = ABOUT;
  end
  always_ff @(posedge Clock) begin
    state_q <= state_d;
  end
  always_comb begin
    divert = (state_q == BIN) || (state_q == ASTOP);
    SW = {SW_STRAIGHT, divert ? SW_DIVERT : SW_STRAIGHT, divert ? SW_DIVERT : SW_STRAIGHT};
    DA = (state_q == ASTOP) ? DIR_STOP : DIR_FWD;
    DB = (state_q == BSTOP) ? DIR_STOP : DIR_FWD;
  end
endmodule

// File: tb/tb_train_state.sv
// tb_train_state: random and directed stimulus against an ownership-based model of the shared section.
module tb_train_state;
`ifdef TRAIN_STATE_SENSOR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:1] sr = 4'b0000;
  logic [3:1] sw;
  logic [1:0] da, db;
  int checks = 0;
  int errors = 0;
  int owner = 0;
  bit wait_a = 1'b0;
  bit wait_b = 1'b0;
  bit started = 1'b0;
  logic [4:1] hist[$];
  logic [4:1] e;
  logic [6:0] exp_out;
  train_state dut (.Clock(clk), .RESET(rst), .SR(sr), .SW(sw), .DA(da), .DB(db));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got sw/da/db=%b required=%b", name, $time, got, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      owner = 0;
      wait_a = 1'b0;
      wait_b = 1'b0;
      started = 1'b1;
      hist.delete();
      repeat (LAT - 1) hist.push_back(4'b0000);
    end else if (started) begin
      hist.push_back(sr);
      e = hist.pop_front();
      if (owner == 0) begin
        if (e[1]) owner = 1;
        else if (e[2]) owner = 2;
      end else if (wait_a) begin
        if (e[3]) wait_a = 1'b0;
      end else if (wait_b) begin
        if (e[4]) wait_b = 1'b0;
      end else if (owner == 1) begin
        if (e[2]) wait_b = 1'b1;
        else if (e[4]) owner = 0;
      end else begin
        if (e[1]) wait_a = 1'b1;
        else if (e[3]) owner = 0;
      end
    end
    exp_out = {(owner == 2) ? 3'b011 : 3'b000, wait_a ? 2'b00 : 2'b01, wait_b ? 2'b00 : 2'b01};
    #1;
    if (started) chk("model", {sw, da, db}, exp_out);
  end
  task automatic step(input logic [4:1] v, input logic [6:0] exp, input string name);
    @(negedge clk);
    rst = 1'b0;
    sr = v;
    @(negedge clk);
    sr = 4'b0000;
    repeat (LAT - 1) @(negedge clk);
    chk(name, {sw, da, db}, exp);
  endtask
  initial begin
    @(negedge clk);
    rst = 1'b1;
    sr = 4'b0001;
    repeat (2) @(negedge clk);
    chk("reset", {sw, da, db}, 7'b000_01_01);
    step(4'b0100, 7'b000_01_01, "about_ignore_sr3");
    step(4'b1010, 7'b011_01_01, "about_to_bin");
    step(4'b0100, 7'b000_01_01, "bin_to_about");
    step(4'b0001, 7'b000_01_01, "about_to_ain");
    step(4'b1000, 7'b000_01_01, "ain_to_about");
    step(4'b0010, 7'b011_01_01, "about_to_bin2");
    step(4'b0001, 7'b011_00_01, "bin_to_astop");
    step(4'b0100, 7'b011_01_01, "astop_to_bin");
    step(4'b0100, 7'b000_01_01, "bin_to_about2");
    step(4'b0001, 7'b000_01_01, "about_to_ain2");
    step(4'b1010, 7'b000_01_00, "ain_to_bstop");
    step(4'b1000, 7'b000_01_01, "bstop_to_ain");
    step(4'b1000, 7'b000_01_01, "ain_to_about2");
    step(4'b0010, 7'b011_01_01, "about_to_bin3");
    step(4'b0001, 7'b011_00_01, "bin_to_astop2");
    @(negedge clk);
    rst = 1'b1;
    sr = 4'b0100;
    @(negedge clk);
    chk("reset_mid", {sw, da, db}, 7'b000_01_01);
    rst = 1'b0;
    sr = 4'b0010;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      chk("latency", {sw, da, db}, (i < LAT) ? 7'b000_01_01 : 7'b011_01_01);
      sr = 4'b0000;
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 39) == 0);
      sr = 4'($urandom & $urandom);
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
